csr_wport_arb: RTL
==================

// Module: csr_wport_arb
// PURPOSE
//  Arbitrates the single CSR register-file write port between two requesters:
//  the trap sequencer (mepc/mcause/mstatus burst) and the EX-stage CSR instructions.
//  Trap writes have absolute priority and lock the port for the whole burst.
//  A one-entry hold buffer absorbs an EX write that arrives during a burst; a watchdog breaks a hung lock.
//  Sits between clint/EX and csr_reg.
// PARAMETERS
//  ADDR_W    12   CSR address width
//  DATA_W    64   CSR data width
//  LOCK_MAX  8    max idle cycles in LOCK between trap writes before forced release (>=2)
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous reset, active-high
//  trap_req_i   in   1       trap sequencer write request (1 write per cycle asserted)
//  trap_last_i  in   1       qualifies trap_req_i: final write of the burst
//  trap_addr_i  in   ADDR_W  trap write address
//  trap_data_i  in   DATA_W  trap write data
//  ex_req_i     in   1       EX CSR write request; held until ex_gnt_o
//  ex_addr_i    in   ADDR_W  EX write address
//  ex_data_i    in   DATA_W  EX write data
//  flush_i      in   1       pipeline flush: discards held EX write
//  ex_gnt_o     out  1       EX write accepted this cycle (combinational)
//  ex_stall_o   out  1       ex_req_i & ~ex_gnt_o (combinational)
//  csr_we_o     out  1       registered write enable to csr_reg
//  csr_waddr_o  out  ADDR_W  registered write address
//  csr_wdata_o  out  DATA_W  registered write data
//  lock_err_o   out  1       one-cycle pulse: watchdog forced lock release
// BEHAVIOUR
//  Reset: state=IDLE, hold_v=0, wdog=0; csr_we_o=0, csr_waddr_o=0, csr_wdata_o=0, lock_err_o=0.
//  Latency: granted write appears on csr_we_o/addr/data exactly 1 cycle after grant; csr_we_o=0 otherwise (addr/data zero).
//  IDLE:
//  - trap_req: trap write issued; go DRAIN if trap_last & hold_v, IDLE if trap_last, else LOCK.
//  - Same-cycle ex_req: captured into hold (ex_gnt_o=1), hold_v=1.
//  - ex_req alone: granted and issued directly.
//  LOCK:
//  - trap_req: write issued, wdog cleared; trap_last -> DRAIN if hold_v, else IDLE.
//  - ex_req with hold empty: captured, ex_gnt_o=1. With hold full: ex_gnt_o=0 (stall).
//  - No trap_req: wdog++. wdog==LOCK_MAX-1: lock_err_o pulses next cycle, wdog=0; go DRAIN if hold_v, else IDLE.
//  DRAIN:
//  - trap_req: trap write issued, handled as in IDLE; hold retained.
//  - Else: held write issued, hold_v=0 -> IDLE.
//  - ex_req always stalled in DRAIN to preserve program order.
//  flush_i:
//  - Clears hold_v the same cycle and overrides a same-cycle capture (ex_gnt_o still 1; write dropped).
//  - DRAIN with hold cleared -> IDLE without a write.
//  Never more than one csr_we_o per cycle; trap write always wins any same-cycle contest.
//  Addresses/data pass unmodified; no address decode or merging.
//  trap_last_i is ignored when trap_req_i=0.
//  Reset asserted mid-burst: immediate return to reset values; held write lost; outputs zero same instant (async).
// TESTING
//  1. ex_req, addr=0x300, data=0x8 in IDLE -> ex_gnt_o=1; next cycle csr_we_o=1, waddr=0x300, wdata=0x8.
//  2. 3-cycle trap burst 0x341/0x342/0x300 (last on 3rd), EX 0x305 req on cycle 2:
//     -> trap writes on cycles 2,3,4; EX captured (gnt) on cycle 2; 0x305 written cycle 5; state IDLE cycle 6.
//  3. Two EX reqs during LOCK -> first captured, second sees ex_gnt_o=0, ex_stall_o=1 until DRAIN completes,
//     then granted from IDLE.
//  4. Trap req without last, then trap_req low 8 cycles (LOCK_MAX=8) -> lock_err_o one-cycle pulse; state IDLE;
//     no spurious csr_we_o.
//  5. EX captured in LOCK, flush_i on trap_last cycle -> no EX write issued; IDLE after burst.
//  6. rst asserted mid-LOCK with hold_v=1 -> csr_we_o=0 immediately; after release, first ex_req handled as in IDLE.

Source files
------------

// File: rtl/csr_wport_arb.sv
// CSR write-port arbiter: trap sequencer bursts lock the port. A one-entry hold buffer
// parks an EX write that arrives during a burst, and a watchdog frees a lock that has gone quiet.
module csr_wport_arb #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 64,
    parameter int LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trap_req_i,
    input  logic              trap_last_i,
    input  logic [ADDR_W-1:0] trap_addr_i,
    input  logic [DATA_W-1:0] trap_data_i,
    input  logic              ex_req_i,
    input  logic [ADDR_W-1:0] ex_addr_i,
    input  logic [DATA_W-1:0] ex_data_i,
    input  logic              flush_i,
    output logic              ex_gnt_o,
    output logic              ex_stall_o,
    output logic              csr_we_o,
    output logic [ADDR_W-1:0] csr_waddr_o,
    output logic [DATA_W-1:0] csr_wdata_o,
    output logic              lock_err_o
);

    // state | meaning
    // IDLE  | port free; EX writes go straight through
    // LOCK  | trap burst in progress; EX writes may only be parked
    // DRAIN | burst over; parked EX write goes out before any new EX write
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int WD_W = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
    localparam logic [WD_W-1:0] WD_INIT = WD_W'(LOCK_MAX - 1);

    state_t            state_q, state_d;
    logic              hold_v_q, hold_v_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              lock_err_q, lock_err_d;
    logic              gnt;
    logic              capture;
    logic              wdog_fire;

    always_comb begin
        state_d     = state_q;
        hold_v_d    = hold_v_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        wdog_d      = WD_INIT;
        we_d        = 1'b0;
        waddr_d     = '0;
        wdata_d     = '0;
        lock_err_d  = 1'b0;
        gnt         = 1'b0;
        capture     = 1'b0;
        wdog_fire   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                gnt = ex_req_i;
                if (trap_req_i) begin
                    we_d    = 1'b1;
                    waddr_d = trap_addr_i;
                    wdata_d = trap_data_i;
                    capture = ex_req_i;
                end else if (ex_req_i) begin
                    we_d    = 1'b1;
                    waddr_d = ex_addr_i;
                    wdata_d = ex_data_i;
                end
            end
            ST_LOCK: begin
                gnt     = ex_req_i & ~hold_v_q;
                capture = gnt;
                if (trap_req_i) begin
                    we_d    = 1'b1;
                    waddr_d = trap_addr_i;
                    wdata_d = trap_data_i;
                end else if (wdog_q == '0) begin
                    wdog_fire  = 1'b1;
                    lock_err_d = 1'b1;
                end else begin
                    wdog_d = wdog_q - 1'b1;
                end
            end
            ST_DRAIN: begin
                if (trap_req_i) begin
                    we_d    = 1'b1;
                    waddr_d = trap_addr_i;
                    wdata_d = trap_data_i;
                end else begin
                    if (hold_v_q && !flush_i) begin
                        we_d    = 1'b1;
                        waddr_d = hold_addr_q;
                        wdata_d = hold_data_q;
                    end
                    hold_v_d = 1'b0;
                end
            end
            default: ;
        endcase

        if (capture) begin
            hold_v_d    = 1'b1;
            hold_addr_d = ex_addr_i;
            hold_data_d = ex_data_i;
        end
        // A flush wins over a capture in the same cycle; the grant still stands.
        if (flush_i) begin
            hold_v_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE, ST_DRAIN: begin
                if (trap_req_i) begin
                    if (!trap_last_i)  state_d = ST_LOCK;
                    else if (hold_v_d) state_d = ST_DRAIN;
                    else               state_d = ST_IDLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCK: begin
                if ((trap_req_i && trap_last_i) || wdog_fire) begin
                    state_d = hold_v_d ? ST_DRAIN : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hold_v_q    <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            wdog_q      <= WD_INIT;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            lock_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_v_q    <= hold_v_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            wdog_q      <= wdog_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            lock_err_q  <= lock_err_d;
        end
    end

    assign ex_gnt_o    = gnt;
    assign ex_stall_o  = ex_req_i & ~gnt;
    assign csr_we_o    = we_q;
    assign csr_waddr_o = waddr_q;
    assign csr_wdata_o = wdata_q;
    assign lock_err_o  = lock_err_q;

endmodule
